// File: rtl/mux_scan_pkg.sv
// Shared definitions for the selector bit scanner.
//   - scan_state_t : scanner FSM states
//   - NBITS / SEL_W / CNT_W : word width, select width, settle counter width
//   - first_index / last_index : scan order endpoints for a given direction
package mux_scan_pkg;

  localparam int NBITS = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_WAIT = 2'd1,
    SAMPLE      = 2'd2,
    COMMIT      = 2'd3
  } scan_state_t;

  // Index the scan starts from (also the parking value of sel while idle).
  function automatic logic [SEL_W-1:0] first_index(input bit msb_first);
    return msb_first ? SEL_W'(NBITS - 1) : '0;
  endfunction

  // Index whose sample ends the scan.
  function automatic logic [SEL_W-1:0] last_index(input bit msb_first);
    return msb_first ? '0 : SEL_W'(NBITS - 1);
  endfunction

endpackage

// File: rtl/mux_scan_timer.sv
// Loadable down-counter used to time the selector settle interval.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : load count with load_value (has priority over en)
//   en          : decrement by one per cycle; holds at zero
//   load_value  : value loaded on load
//   count       : current count
//   zero        : count == 0
module mux_scan_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/mux_bit_scanner.sv
// Sequencer that walks an 8-to-1 selector through all of its inputs and
// assembles the selected bits into a parallel word.
// Parameters:
//   SETTLE    : idle cycles after each select change before Q is sampled (0..15)
//   MSB_FIRST : 0 scans index 0..7, 1 scans 7..0 (bit mapping is unchanged)
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : request a scan (taken only in IDLE)
//   abort      : cancel a scan in progress
//   q_in       : selector Q output
//   sel        : selector SEL2..SEL0
//   ce_n       : selector enable, active low
//   busy       : scan in progress
//   done       : one-cycle pulse, data_out carries a fresh result
//   data_out   : last completed scan result
module mux_bit_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE    = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             q_in,
  output logic [SEL_W-1:0] sel,
  output logic             ce_n,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] data_out
);

  localparam logic [SEL_W-1:0] FIRST_IDX  = first_index(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_IDX   = last_index(MSB_FIRST);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  // With no settle time every bit is a single SAMPLE cycle.
  localparam bit               NO_SETTLE  = (SETTLE == 0);

  scan_state_t      state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [NBITS-1:0] shadow_reg, shadow_next;
  logic [NBITS-1:0] data_reg;

  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_zero;
  logic             settle_last;
  logic             commit_ok;

  mux_scan_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .en         (tmr_en),
    .load_value (SETTLE_CNT),
    .count      (tmr_count),
    .zero       (tmr_zero)
  );

  // The wait ends on the cycle whose decrement brings the count to zero,
  // so a count loaded with SETTLE yields exactly SETTLE wait cycles.
  assign settle_last = tmr_zero || (tmr_count == CNT_W'(1));

  // An abort landing in the COMMIT cycle must suppress the update, so the
  // commit qualifier looks at abort directly.
  assign commit_ok = (state_reg == COMMIT) && !abort;

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    shadow_next = shadow_reg;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    busy        = 1'b0;
    ce_n        = 1'b1;
    done        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // start is ignored when abort arrives in the same cycle
        if (start && !abort) begin
          sel_next   = FIRST_IDX;
          tmr_load   = 1'b1;
          state_next = NO_SETTLE ? SAMPLE : SETTLE_WAIT;
        end
      end
      SETTLE_WAIT: begin
        busy   = 1'b1;
        ce_n   = 1'b0;
        tmr_en = 1'b1;
        if (settle_last) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        busy                 = 1'b1;
        ce_n                 = 1'b0;
        shadow_next[sel_reg] = q_in;
        if (sel_reg == LAST_IDX) begin
          state_next = COMMIT;
        end else begin
          sel_next   = MSB_FIRST ? (sel_reg - SEL_W'(1)) : (sel_reg + SEL_W'(1));
          tmr_load   = 1'b1;
          state_next = NO_SETTLE ? SAMPLE : SETTLE_WAIT;
        end
      end
      COMMIT: begin
        done       = commit_ok;
        sel_next   = FIRST_IDX;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // abort overrides every transition out of a non-idle state
    if (abort && (state_reg != IDLE)) begin
      state_next  = IDLE;
      sel_next    = FIRST_IDX;
      shadow_next = '0;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      sel_reg    <= FIRST_IDX;
      shadow_reg <= '0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      shadow_reg <= shadow_next;
      if (commit_ok) begin
        data_reg <= shadow_reg;
      end
    end
  end

  assign sel = sel_reg;

  // The result is visible in the same cycle as the done pulse; the held
  // register picks it up at the end of that cycle.
  assign data_out = commit_ok ? shadow_reg : data_reg;

endmodule
